// File: rtl/tqv_peripheral_harness.sv
// tqv_peripheral_harness
//   TinyTapeout wrapper hosting one TinyQV-style peripheral whose register
//   bus is reached through an SPI mode-0 slave on the bidirectional pins.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   ena             design select (unused)
//   ui_in/uo_out    dedicated pins, wired straight to the peripheral
//   uio_in          [0] CS_n, [1] MOSI, [3] SCK
//   uio_out         [2] MISO, [4] peripheral interrupt, others 0
//   uio_oe          constant 8'b0001_0100

module tqv_mc_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] sel,
  input  logic [5:0] wdata,
  output logic [5:0] rdata
);
  logic [5:0] amps [0:3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) amps[i] <= '0;
    end else if (wr_en) begin
      amps[sel] <= wdata;
    end
  end

  assign rdata = amps[sel];
endmodule

// Minimal peripheral: reg0 at 0 (width-masked writes), interrupt flag at 1,
// ui_in readback at 2, four 6-bit amplitudes at 8..11.
module tqv_user_peripheral (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  logic [31:0] reg0;
  logic        irq;
  logic        wr;
  logic        amp_sel;
  logic [5:0]  amp_rd;

  assign wr      = (data_write_n != 2'b11);
  assign amp_sel = (address[5:2] == 4'd2);

  tqv_mc_alu mc_alu_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr && amp_sel),
    .sel   (address[1:0]),
    .wdata (data_in[5:0]),
    .rdata (amp_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg0       <= '0;
      irq        <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= (data_read_n != 2'b11) && !data_ready;
      if (wr && address == 6'd0) begin
        case (data_write_n)
          2'b00:   reg0[7:0]  <= data_in[7:0];
          2'b01:   reg0[15:0] <= data_in[15:0];
          default: reg0       <= data_in;
        endcase
      end
      if (wr && address == 6'd1) irq <= data_in[0];
    end
  end

  always_comb begin
    data_out = '0;
    if (address == 6'd0)      data_out = reg0;
    else if (address == 6'd1) data_out = {31'b0, irq};
    else if (address == 6'd2) data_out = {24'b0, ui_in};
    else if (amp_sel)         data_out = {26'b0, amp_rd};
  end

  assign uo_out         = reg0[7:0];
  assign user_interrupt = irq;
endmodule

module tqv_peripheral_harness (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RWAIT, S_RDATA, S_DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  cs_sync, mosi_sync, sck_sync;
  logic        cs_prev, sck_prev;
  logic        cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;
  logic [5:0]  bit_cnt, last_idx;
  logic [31:0] shreg, cmd_word, aligned;
  logic [1:0]  wcode, wcode_cmd;
  logic        rd_armed, miso;

  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;

  logic        unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4], uio_in[2]};

  tqv_user_peripheral user_peripheral (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= 2'b11;
      mosi_sync <= '0;
      sck_sync  <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], uio_in[0]};
      mosi_sync <= {mosi_sync[0], uio_in[1]};
      sck_sync  <= {sck_sync[0], uio_in[3]};
      cs_prev   <= cs_sync[1];
      sck_prev  <= sck_sync[1];
    end
  end

  assign mosi_s   = mosi_sync[1];
  assign cs_fall  = cs_prev & ~cs_sync[1];
  assign cs_rise  = ~cs_prev & cs_sync[1];
  assign sck_rise = ~sck_prev & sck_sync[1];
  assign sck_fall = sck_prev & ~sck_sync[1];

  assign cmd_word  = {shreg[30:0], mosi_s};
  assign wcode_cmd = (cmd_word[30:29] == 2'b11) ? 2'b10 : cmd_word[30:29];

  always_comb begin
    case (wcode)
      2'b00:   begin last_idx = 6'd7;  aligned = data_out << 24; end
      2'b01:   begin last_idx = 6'd15; aligned = data_out << 16; end
      default: begin last_idx = 6'd31; aligned = data_out;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // In RDATA a fall only advances MISO once a rise has been seen there; this
  // keeps the trailing fall of the last command bit from consuming a data bit.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cs_fall) state_next = S_CMD;
        S_CMD:   if (sck_rise && bit_cnt == 6'd31)
                   state_next = cmd_word[31] ? S_WDATA : S_RWAIT;
        S_WDATA: if (sck_rise && bit_cnt == last_idx) state_next = S_DONE;
        S_RWAIT: if (data_ready) state_next = S_RDATA;
        S_RDATA: if (sck_fall && rd_armed && bit_cnt == last_idx) state_next = S_DONE;
        S_DONE:  state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      wcode        <= 2'b10;
      rd_armed     <= 1'b0;
      miso         <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= 2'b11;
      data_read_n  <= 2'b11;
    end else begin
      data_write_n <= 2'b11;
      if (cs_rise) begin
        data_read_n <= 2'b11;
        miso        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (cs_fall) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            miso     <= 1'b0;
            rd_armed <= 1'b0;
          end
          S_CMD: if (sck_rise) begin
            if (bit_cnt == 6'd31) begin
              wcode   <= wcode_cmd;
              address <= cmd_word[5:0];
              bit_cnt <= '0;
              shreg   <= '0;
              if (!cmd_word[31]) data_read_n <= wcode_cmd;
            end else begin
              shreg   <= cmd_word;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_WDATA: if (sck_rise) begin
            if (bit_cnt == last_idx) begin
              data_in      <= cmd_word;
              data_write_n <= wcode;
            end else begin
              shreg   <= cmd_word;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_RWAIT: if (data_ready) begin
            data_read_n <= 2'b11;
            shreg       <= aligned;
            miso        <= aligned[31];
            bit_cnt     <= '0;
            rd_armed    <= 1'b0;
          end
          S_RDATA: begin
            if (sck_rise) begin
              rd_armed <= 1'b1;
            end else if (sck_fall && rd_armed) begin
              rd_armed <= 1'b0;
              if (bit_cnt == last_idx) begin
                miso <= 1'b0;
              end else begin
                shreg   <= shreg << 1;
                miso    <= shreg[30];
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign uio_out = {3'b000, user_interrupt, 1'b0, miso, 2'b00};
  assign uio_oe  = 8'b0001_0100;
endmodule

// File: tb/tb_tqv_peripheral_harness.sv
module tb_tqv_peripheral_harness;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       cs_n, mosi, sck;

  always #5 clk = ~clk;
  assign uio_in = {4'b0000, sck, 1'b0, mosi, cs_n};

  tqv_peripheral_harness dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int tests = 0;
  int fails = 0;
  logic checking = 1'b0;

  typedef struct {
    logic [1:0]  code;
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t cur;

  // Peripheral register model
  logic [31:0] m_reg0;
  logic        m_irq;
  logic [5:0]  m_amps [0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input logic [31:0] cmd);
    return (cmd[30:29] == 2'b11) ? 2'b10 : cmd[30:29];
  endfunction

  function automatic int nbits(input logic [1:0] code);
    return (code == 2'b00) ? 8 : (code == 2'b01) ? 16 : 32;
  endfunction

  function automatic logic [31:0] trunc(input logic [1:0] code, input logic [31:0] v);
    return (code == 2'b00) ? (v & 32'hFF) : (code == 2'b01) ? (v & 32'hFFFF) : v;
  endfunction

  task automatic model_reset();
    m_reg0 = '0;
    m_irq  = 1'b0;
    for (int i = 0; i < 4; i++) m_amps[i] = '0;
  endtask

  task automatic model_write(input logic [1:0] code, input logic [5:0] addr, input logic [31:0] d);
    if (addr == 6'd0) begin
      if (code == 2'b00)      m_reg0[7:0]  = d[7:0];
      else if (code == 2'b01) m_reg0[15:0] = d[15:0];
      else                    m_reg0       = d;
    end else if (addr == 6'd1) begin
      m_irq = d[0];
    end else if (addr >= 6'd8 && addr <= 6'd11) begin
      m_amps[addr - 6'd8] = d[5:0];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] addr);
    if (addr == 6'd0) return m_reg0;
    if (addr == 6'd1) return {31'b0, m_irq};
    if (addr == 6'd2) return {24'b0, ui_in};
    if (addr >= 6'd8 && addr <= 6'd11) return {26'b0, m_amps[addr - 6'd8]};
    return '0;
  endfunction

  // Per-cycle compare: constant pins, unused output bits, and every write
  // strobe against the queue of writes the stimulus expects.
  always @(negedge clk) begin
    if (checking) begin
      check("uio_oe", {24'b0, uio_oe}, 32'h14);
      check("uio_out_unused_bits", {24'b0, uio_out & 8'hEB}, 32'h0);
      if (dut.data_write_n !== 2'b11) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got code %b addr %0d, expected no strobe",
                   dut.data_write_n, dut.address);
        end else begin
          cur = exp_q.pop_front();
          check("strobe_code", {30'b0, dut.data_write_n}, {30'b0, cur.code});
          check("strobe_addr", {26'b0, dut.address}, {26'b0, cur.addr});
          check("strobe_data", dut.data_in, cur.data);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    mosi = b;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] cmd, input logic [31:0] wdata,
                           input int bits_sent, output logic [31:0] rdata);
    int n;
    n = nbits(code_of(cmd));
    rdata = '0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 31; i >= 0; i--) send_bit(cmd[i]);
    if (cmd[31]) begin
      for (int i = 0; i < bits_sent; i++) send_bit(wdata[n - 1 - i]);
    end else begin
      repeat (20) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        rdata = {rdata[30:0], uio_out[2]};
        sck = 1'b1;
        repeat (5) @(negedge clk);
        sck = 1'b0;
        repeat (5) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_write(input logic [31:0] cmd, input logic [31:0] d, input int bits_sent);
    logic [1:0]  code;
    logic [31:0] dummy;
    wr_t         e;
    code = code_of(cmd);
    if (bits_sent >= nbits(code)) begin
      e.code = code;
      e.addr = cmd[5:0];
      e.data = trunc(code, d);
      exp_q.push_back(e);
    end
    spi_frame(cmd, d, bits_sent, dummy);
    if (bits_sent >= nbits(code)) model_write(code, cmd[5:0], trunc(code, d));
    check("strobe_pending", exp_q.size(), 0);
  endtask

  task automatic spi_read(input string name, input logic [31:0] cmd, input logic [31:0] lit);
    logic [31:0] r;
    spi_frame(cmd, '0, 0, r);
    check({name, "_model"}, r, trunc(code_of(cmd), model_read(cmd[5:0])));
    check({name, "_literal"}, r, lit);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cs_n = 1'b1; mosi = 1'b0; sck = 1'b0;
    ena = 1'b1; ui_in = 8'h00; rst_n = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check("rst_uio_oe", {24'b0, uio_oe}, 32'h14);
    check("rst_uio_out", {24'b0, uio_out}, 32'h0);
    check("rst_write_n", {30'b0, dut.data_write_n}, 32'h3);
    check("rst_read_n", {30'b0, dut.data_read_n}, 32'h3);
    for (int i = 0; i < 4; i++)
      check("rst_amp", {26'b0, dut.user_peripheral.mc_alu_unit.amps[i]}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;

    spi_write(32'hC000_0005, 32'h1234_5678, 32);
    spi_write(32'h8000_0003, 32'h0000_00A5, 8);

    spi_write(32'hC000_0000, 32'hDEAD_BEEF, 32);
    spi_read("rd32", 32'h4000_0000, 32'hDEAD_BEEF);
    spi_read("rd16", 32'h2000_0000, 32'h0000_BEEF);
    check("uo_out", {24'b0, uo_out}, 32'hEF);

    // Abort mid-write: CS_n rises after 20 of 32 data bits
    spi_write(32'hC000_0000, 32'hCAFE_F00D, 20);
    spi_read("after_abort", 32'h4000_0000, 32'hDEAD_BEEF);
    spi_write(32'hC000_0005, 32'h0BAD_F00D, 32);

    spi_write(32'h8000_0000, 32'h0000_00A5, 8);
    spi_read("rd32_byte_merge", 32'h4000_0000, 32'hDEAD_BEA5);
    spi_read("rd8", 32'h0000_0000, 32'h0000_00A5);

    ui_in = 8'h5A;
    @(negedge clk);
    check("ui_in_pass", {24'b0, dut.user_peripheral.ui_in}, 32'h5A);
    spi_read("rd_ui_in", 32'h0000_0002, 32'h0000_005A);

    spi_write(32'h8000_0001, 32'h1, 8);
    check("irq_high", {31'b0, uio_out[4]}, 32'h1);
    spi_write(32'h8000_0001, 32'h0, 8);
    check("irq_low", {31'b0, uio_out[4]}, 32'h0);

    spi_write(32'h8000_0009, 32'h2B, 8);
    check("amp1", {26'b0, dut.user_peripheral.mc_alu_unit.amps[1]}, 32'h2B);
    spi_read("rd_amp1", 32'h0000_0009, 32'h0000_002B);
    spi_write(32'hA000_000B, 32'h1234, 16);
    check("amp3", {26'b0, dut.user_peripheral.mc_alu_unit.amps[3]}, 32'h34);

    // Width code 11 behaves as 32-bit
    spi_write(32'hE000_0000, 32'h1357_9BDF, 32);
    spi_read("rd_code11", 32'h6000_0000, 32'h1357_9BDF);

    // Reset in the middle of a write: no strobe, registers cleared
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    begin
      logic [31:0] c;
      c = 32'hC000_0000;
      for (int i = 31; i >= 0; i--) send_bit(c[i]);
    end
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_write_n", {30'b0, dut.data_write_n}, 32'h3);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_read("after_reset", 32'h4000_0000, 32'h0000_0000);
    spi_write(32'hC000_0000, 32'hA5A5_0F0F, 32);
    spi_read("post_reset_rw", 32'h4000_0000, 32'hA5A5_0F0F);

    check("final_queue", exp_q.size(), 0);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
